// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared definitions for the RV32I load/store unit.
//   - funct3 encodings for the supported loads/stores
//   - FSM state encoding for load_store_unit
//   - f3_legal / misaligned request decode helpers
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // Stores only exist as B/H/W; the unsigned forms are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   i_word     : word read from memory
//   i_addr_lo  : byte offset within the word
//   i_funct3   : access size / signedness
//   i_wdata    : store data (low bits used for B/H)
//   o_load     : selected lane, sign- or zero-extended
//   o_store    : i_word with only the addressed byte/half replaced by i_wdata
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [31:0] w_byte_word;
  logic [31:0] w_half_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  // Halfwords only look at addr[1]; addr[0] is either trapped upstream or ignored.
  assign w_byte_sh   = {i_addr_lo, 3'b000};
  assign w_half_sh   = {i_addr_lo[1], 4'b0000};
  assign w_byte_word = i_word >> w_byte_sh;
  assign w_half_word = i_word >> w_half_sh;
  assign w_byte      = w_byte_word[7:0];
  assign w_half      = w_half_word[15:0];
  assign w_byte_mask = 32'h0000_00ff << w_byte_sh;
  assign w_half_mask = 32'h0000_ffff << w_half_sh;

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h000000, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase
  end

  // Only legal stores reach here, so funct3[2] is always 0.
  always_comb begin
    o_store = i_wdata;
    case (i_funct3[1:0])
      2'b00:   o_store = (i_word & ~w_byte_mask) | ((i_wdata << w_byte_sh) & w_byte_mask);
      2'b01:   o_store = (i_word & ~w_half_mask) | ((i_wdata << w_half_sh) & w_half_mask);
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the RV32I data-memory port.
//   Request  : req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata
//   Response : resp_valid (one-cycle pulse), resp_rdata (extended load data, 0 for stores),
//              resp_err (illegal funct3 or, when trapping, misaligned access)
//   Memory   : mem_we, mem_a (word aligned), mem_wd, mem_rd (asynchronous read)
//   Sub-word stores are read-modify-write because the memory writes whole words only.
//   Build option: define MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses; otherwise
//   the offending low address bits are ignored.
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_d;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_accept;
  logic              w_req_err;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_store;

`ifdef MISALIGN_TRAP_EN
  assign w_req_err = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_req_err = !f3_legal(req_we, req_funct3);
`endif

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err)                      w_state_d = S_RESP;
          else if (req_we && req_funct3 == F3_W) w_state_d = S_WRITE;
          else                                w_state_d = S_READ;
        end
      end
      S_READ:  w_state_d = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_state_d = S_RESP;
      S_RESP:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_d;
  end

  // r_wd first holds the raw store data, then the merged word for B/H stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wd     <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_req_err;
      end
      if (r_state == S_READ) begin
        if (r_we) r_wd    <= w_store;
        else      r_rdata <= w_load;
      end
    end
  end

  lsu_lane_align u_lane_align (
    .i_word    (mem_rd),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .i_wdata   (r_wd),
    .o_load    (w_load),
    .o_store   (w_store)
  );

  // Control outputs decode straight from state so reset drops them immediately.
  assign req_ready  = (r_state == S_IDLE);
  assign mem_we     = (r_state == S_WRITE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_a      = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wd     = r_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized + directed scoreboard bench for load_store_unit.
// A byte-addressed reference memory predicts each response; a monitor checks responses,
// memory writes and latency as the DUT produces them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Environment data memory: async read, sync write, plus a bench preload port.
  logic [31:0] env_mem [0:4095];
  logic        pre_we = 1'b0;
  logic [31:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  assign mem_rd = env_mem[mem_a[13:2]];
  always @(posedge clk) begin
    if (mem_we)      env_mem[mem_a[13:2]] <= mem_wd;
    else if (pre_we) env_mem[pre_a[13:2]] <= pre_d;
  end

  // Reference model: plain byte array.
  logic [7:0] ref_mem [0:16383];

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          wr;
    logic [31:0] wd;
    logic [31:0] wa;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   wr_seen = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int ea;
    ea = int'(a[13:0]) & ~3;
    return {ref_mem[ea+3], ref_mem[ea+2], ref_mem[ea+1], ref_mem[ea]};
  endfunction

  function automatic exp_t model(input string nm, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   ba;
    int   ha;
    logic legal;
    logic mis;
    logic [15:0] h;
    e.name = nm; e.rdata = '0; e.err = 1'b0; e.lat = 0; e.acc = 0; e.wr = 0; e.wd = '0;
    e.wa = a & ~32'd3;
    ba = int'(a[13:0]);
    ha = ba & ~1;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (!legal || mis) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    if (we) begin
      if (f3 == 3'd0) begin
        ref_mem[ba] = wd[7:0];
      end else if (f3 == 3'd1) begin
        ref_mem[ha] = wd[7:0];
        ref_mem[ha+1] = wd[15:8];
      end else begin
        for (int i = 0; i < 4; i++) ref_mem[(ba & ~3) + i] = wd[8*i +: 8];
      end
      e.wr  = 1;
      e.wd  = ref_word(a);
      e.lat = (f3 == 3'd2) ? 2 : 3;
    end else begin
      e.lat = 2;
      h = {ref_mem[ha+1], ref_mem[ha]};
      case (f3)
        3'd0: e.rdata = {{24{ref_mem[ba][7]}}, ref_mem[ba]};
        3'd4: e.rdata = {24'd0, ref_mem[ba]};
        3'd1: e.rdata = {{16{h[15]}}, h};
        3'd5: e.rdata = {16'd0, h};
        default: e.rdata = ref_word(a);
      endcase
    end
    return e;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    int ea;
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = w;
    ea = int'(a[13:0]) & ~3;
    for (int i = 0; i < 4; i++) ref_mem[ea + i] = w[8*i +: 8];
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check({nm, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e = model(nm, we, f3, a, wd);
    e.acc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check({nm, "_busy_after_accept"}, 32'(req_ready), 32'd0);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: checks every memory write and every response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      wr_seen = 0;
    end else begin
      if (mem_we) begin
        if (sb_q.size() == 0) begin
          check("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          check({sb_q[0].name, "_write_expected"}, 32'd1, 32'(sb_q[0].wr));
          check({sb_q[0].name, "_mem_wd"}, mem_wd, sb_q[0].wd);
          check({sb_q[0].name, "_mem_a"}, mem_a, sb_q[0].wa);
        end
        wr_seen++;
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
          check({mon_e.name, "_err"}, 32'(resp_err), 32'(mon_e.err));
          check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          check({mon_e.name, "_write_count"}, 32'(wr_seen), 32'(mon_e.wr));
        end
        wr_seen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;
    int          bad_words;
    int          g;

    // Reset state and memory initialisation (rst_n held low).
    #1;
    reset_checks("reset_initial");
    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
    preload(32'h0000_2000, 32'h0000_00ff);
    preload(32'h0000_0010, 32'h1122_3344);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the WRITE cycle of an SB aborts it without touching memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h12; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!mem_we && g < 6);
    check("rst_sb_reached_write", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_sb_mem_we_drop", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    check("rst_sb_mem_unchanged", env_mem[4], ref_word(32'h10));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("reset_after_abort");
    mon_en = 1'b1;

    // Directed cases.
    issue("lb_ff",   1'b0, 3'b000, 32'h2000, 32'h0, 1'b0);
    issue("lbu_ff",  1'b0, 3'b100, 32'h2000, 32'h0, 1'b0);
    issue("sw_19",   1'b1, 3'b010, 32'h2000, 32'h19, 1'b0);
    issue("lw_19",   1'b0, 3'b010, 32'h2000, 32'h0, 1'b0);
    issue("sb_ab",   1'b1, 3'b000, 32'h12, 32'hAB, 1'b0);
    issue("sh_beef", 1'b1, 3'b001, 32'h10, 32'hBEEF, 1'b0);
    issue("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    issue("lh_2001", 1'b0, 3'b001, 32'h2001, 32'h0, 1'b0);
    issue("ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    issue("st_f3_4", 1'b1, 3'b100, 32'h10, 32'hDEAD, 1'b0);
    // Back-to-back: req_valid held high across requests.
    issue("b2b_sb",  1'b1, 3'b000, 32'h21, 32'h7F, 1'b1);
    issue("b2b_err", 1'b0, 3'b111, 32'h20, 32'h0, 1'b1);
    issue("b2b_lb",  1'b0, 3'b000, 32'h21, 32'h0, 1'b1);
    issue("b2b_lhu", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
    drain();

    // Randomized traffic over the preloaded region.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      issue($sformatf("rnd%0d", n), we, f3, a, $urandom, bit'($urandom_range(0, 1)));
    end
    drain();

    // Memory contents must match the reference everywhere the bench touched.
    bad_words = 0;
    for (int i = 0; i < 256; i++)
      if (env_mem[i] !== ref_word(32'(i * 4))) bad_words++;
    if (env_mem[32'h2000 >> 2] !== ref_word(32'h2000)) bad_words++;
    check("final_mem_words_differing", 32'(bad_words), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
